// File: rtl/load_store_unit_if.sv
// Instruction-type package and data-memory bus interface for the load/store unit.
// The LSU drives the master side; the data memory (or a bench model) the slave side.
package lsu_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LUI, I_ADD, I_ADDI, I_BEQ, I_JAL,
    I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW
  } rv32i_instr_e;
endpackage

interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (WAIT) -> DONE, stalling the pipeline meanwhile.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned word/half accesses instead of ignoring alignment bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  rv32i_instr_e             id_ex_instr_type_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              ex_fwd_rs2_data_i,
  input  logic [4:0]               id_ex_rd_addr_i,
  load_store_unit_if.master        dmem,
  output logic                     lsu_stall_o,
  output logic [31:0]              lsu_wb_result_o,
  output logic                     lsu_wb_write_en_o,
  output logic [4:0]               lsu_wb_rd_addr_o,
  output logic                     lsu_bus_error_o,
  output logic                     lsu_misaligned_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [4:0]       rd_q;
  rv32i_instr_e     type_q;
  logic [31:0]      wb_result_q;
  logic             wb_we_q, berr_q;
  logic [4:0]       wb_rd_q;
  logic             is_mem, is_store_q, misaligned, capture, load_done, timeout_hit;

  function automatic logic [3:0] f_be(input rv32i_instr_e t, input logic [1:0] a);
    case (t)
      I_LB, I_LBU, I_SB: return 4'b0001 << a;
      I_LH, I_LHU, I_SH: return 4'b0011 << {a[1], 1'b0};
      default:           return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input rv32i_instr_e t, input logic [31:0] d);
    case (t)
      I_SB:    return {4{d[7:0]}};
      I_SH:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input rv32i_instr_e t, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    case (t)
      I_LB:    return {{24{b[7]}}, b};
      I_LBU:   return {24'h0, b};
      I_LH:    return {{16{h[15]}}, h};
      I_LHU:   return {16'h0, h};
      default: return d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic f_misaligned(input rv32i_instr_e t, input logic [1:0] a);
    case (t)
      I_LW, I_SW:        return a != 2'b00;
      I_LH, I_LHU, I_SH: return a[0];
      default:           return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    is_mem     = id_ex_instr_type_i inside {I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW};
    is_store_q = type_q inside {I_SB, I_SH, I_SW};
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = is_mem && f_misaligned(id_ex_instr_type_i, mem_addr_i[1:0]);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    load_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: if (is_mem) begin
        capture = 1'b1;
        state_d = misaligned ? S_DONE : S_REQ;
      end
      S_REQ: if (dmem.gnt) begin
        state_d = is_store_q ? S_DONE : S_WAIT;
        cnt_d   = '0;
      end
      // rvalid is checked first so a response in the last allowed cycle still completes
      S_WAIT: begin
        if (dmem.rvalid) begin
          load_done = 1'b1;
          state_d   = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wb_result_q <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      berr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_we_q <= 1'b0;
      berr_q  <= timeout_hit;
      if (load_done && rd_q != 5'd0) begin
        wb_we_q     <= 1'b1;
        wb_result_q <= f_extend(type_q, addr_q[1:0], dmem.rdata);
        wb_rd_q     <= rd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= mem_addr_i;
      be_q    <= f_be(id_ex_instr_type_i, mem_addr_i[1:0]);
      wdata_q <= f_wdata(id_ex_instr_type_i, ex_fwd_rs2_data_i);
      rd_q    <= id_ex_rd_addr_i;
      type_q  <= id_ex_instr_type_i;
    end
  end

  assign dmem.req          = (state_q == S_REQ);
  assign dmem.we           = (state_q == S_REQ) && is_store_q;
  assign dmem.addr         = {addr_q[31:2], 2'b00};
  assign dmem.be           = be_q;
  assign dmem.wdata        = wdata_q;
  assign lsu_stall_o       = !rst && (((state_q == S_IDLE) && is_mem) ||
                                      (state_q == S_REQ) || (state_q == S_WAIT));
  assign lsu_misaligned_o  = !rst && (state_q == S_IDLE) && misaligned;
  assign lsu_wb_result_o   = wb_result_q;
  assign lsu_wb_write_en_o = wb_we_q;
  assign lsu_wb_rd_addr_o  = wb_rd_q;
  assign lsu_bus_error_o   = berr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: the bench plays the data memory and checks each access
// against a transaction-level model of sizes, lanes, extension, latency and timeout.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  rv32i_instr_e instr;
  logic [31:0]  addr, sdata;
  logic [4:0]   rd;
  logic         stall, wb_we, berr, misal;
  logic [31:0]  wb_res;
  logic [4:0]   wb_rd;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  load_store_unit_if dmem_if ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_ex_instr_type_i(instr),
    .mem_addr_i        (addr),
    .ex_fwd_rs2_data_i (sdata),
    .id_ex_rd_addr_i   (rd),
    .dmem              (dmem_if.master),
    .lsu_stall_o       (stall),
    .lsu_wb_result_o   (wb_res),
    .lsu_wb_write_en_o (wb_we),
    .lsu_wb_rd_addr_o  (wb_rd),
    .lsu_bus_error_o   (berr),
    .lsu_misaligned_o  (misal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int op_size(input rv32i_instr_e t);
    if (t == I_LB || t == I_LBU || t == I_SB) return 1;
    if (t == I_LH || t == I_LHU || t == I_SH) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input rv32i_instr_e t);
    return t == I_SB || t == I_SH || t == I_SW;
  endfunction

  function automatic int unsigned lane_off(input rv32i_instr_e t, input logic [31:0] a);
    int sz = op_size(t);
    if (sz == 4) return 0;
    return (sz == 2) ? (a % 4) / 2 * 2 : a % 4;
  endfunction

  function automatic bit ref_mis(input rv32i_instr_e t, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % op_size(t)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_be(input rv32i_instr_e t, input logic [31:0] a);
    int unsigned m = (1 << op_size(t)) - 1;
    return 4'(m << lane_off(t, a));
  endfunction

  function automatic logic [31:0] ref_wdata(input rv32i_instr_e t, input logic [31:0] d);
    int sz = op_size(t);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input rv32i_instr_e t, input logic [31:0] a,
                                           input logic [31:0] d);
    longint unsigned v, span;
    int sz = op_size(t);
    if (sz == 4) return d;
    span = longint'(1) << (8 * sz);
    v = (longint'(d) >> (8 * lane_off(t, a))) % span;
    if ((t == I_LB || t == I_LH) && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return 32'(v);
  endfunction

  function automatic rv32i_instr_e rand_mem_op();
    rv32i_instr_e ops[8] = '{I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW};
    return ops[$urandom_range(0, 7)];
  endfunction

  // One full access: issue cycle, gd stalled grant cycles, rvd empty WAIT cycles, then DONE.
  task automatic do_op(input rv32i_instr_e t, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input int gd, input int rvd, input logic [31:0] rdv);
    bit mis = ref_mis(t, a);
    bit ld = !op_store(t);
    bit tmo = ld && !mis && (TO != 0) && (rvd >= TO);
    bit exp_we = ld && !mis && !tmo && (r != 0);
    int nw = tmo ? TO : rvd + 1;
    @(negedge clk);
    instr = t; addr = a; sdata = d; rd = r;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    #1;
    check("issue_stall", stall, 1);
    check("issue_req", dmem_if.req, 0);
    check("issue_misal", misal, mis);
    check("issue_wbwe", wb_we, 0);
    check("issue_berr", berr, 0);
    check("hold_result", wb_res, last_res);
    if (!mis) begin
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        dmem_if.gnt = (i == gd); dmem_if.rvalid = 1'($urandom); dmem_if.rdata = $urandom;
        #1;
        check("req_req", dmem_if.req, 1);
        check("req_we", dmem_if.we, op_store(t));
        check("req_addr", dmem_if.addr, {a[31:2], 2'b00});
        check("req_be", dmem_if.be, ref_be(t, a));
        if (op_store(t)) check("req_wdata", dmem_if.wdata, ref_wdata(t, d));
        check("req_stall", stall, 1);
      end
      if (ld) begin
        for (int i = 0; i < nw; i++) begin
          @(negedge clk);
          dmem_if.gnt = 1'($urandom);
          dmem_if.rvalid = !tmo && (i == rvd);
          dmem_if.rdata = dmem_if.rvalid ? rdv : $urandom;
          #1;
          check("wait_req", dmem_if.req, 0);
          check("wait_stall", stall, 1);
        end
      end
    end
    @(negedge clk);
    dmem_if.gnt = 1'($urandom); dmem_if.rvalid = 1'($urandom); dmem_if.rdata = $urandom;
    instr = rand_mem_op(); addr = $urandom;
    #1;
    check("done_stall", stall, 0);
    check("done_req", dmem_if.req, 0);
    check("done_misal", misal, 0);
    check("done_wbwe", wb_we, exp_we);
    check("done_berr", berr, tmo);
    if (exp_we) begin
      last_res = ref_load(t, a, rdv);
      last_rd  = r;
    end
    check("done_result", wb_res, last_res);
    check("done_rd", wb_rd, last_rd);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    instr = I_ADD; addr = $urandom;
    dmem_if.gnt = 1'($urandom); dmem_if.rvalid = 1'($urandom); dmem_if.rdata = $urandom;
    #1;
    check("idle_stall", stall, 0);
    check("idle_req", dmem_if.req, 0);
    check("idle_wbwe", wb_we, 0);
  endtask

  initial begin
    rst = 1'b1; instr = I_LW; addr = '0; sdata = '0; rd = '0;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", dmem_if.req, 0);
    check("rst_wbwe", wb_we, 0);
    check("rst_result", wb_res, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_berr", berr, 0);
    check("rst_misal", misal, 0);
    @(negedge clk);
    rst = 1'b0; instr = I_ADD;
    idle_cycle();

    do_op(I_SW,  32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 0, 0, '0);
    do_op(I_LB,  32'h0000_0203, '0, 5'd5, 0, 0, 32'h80FF_1234);
    do_op(I_LHU, 32'h0000_0202, '0, 5'd7, 3, 0, 32'h8001_0000);
    do_op(I_LW,  32'h0000_0400, '0, 5'd9, 0, TO, '0);
    do_op(I_LW,  32'h0000_0404, '0, 5'd9, 1, TO - 1, 32'h1234_5678);
    do_op(I_SH,  32'h0000_0101, 32'h0000_ABCD, 5'd0, 0, 0, '0);
    do_op(I_LW,  32'h0000_0008, '0, 5'd0, 0, 0, 32'h5555_AAAA);

    // Reset while waiting for read data: the late response must be dropped.
    @(negedge clk);
    instr = I_LW; addr = 32'h300; rd = 5'd4; dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    @(negedge clk);
    dmem_if.gnt = 1'b1;
    @(negedge clk);
    dmem_if.gnt = 1'b0;
    #1;
    check("mid_wait_stall", stall, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0; instr = I_ADD; dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'hCAFE_F00D;
    #1;
    check("post_rst_stall", stall, 0);
    @(negedge clk);
    dmem_if.rvalid = 1'b0;
    #1;
    check("post_rst_wbwe", wb_we, 0);
    check("post_rst_result", wb_res, 0);
    last_res = '0; last_rd = '0;

    for (int n = 0; n < 150; n++) begin
      int sel = $urandom_range(0, 9);
      int rvd = (sel < 8) ? $urandom_range(0, 3) : (sel == 8) ? TO - 1 : TO + $urandom_range(0, 3);
      logic [4:0] r = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
      do_op(rand_mem_op(), $urandom, $urandom, r, $urandom_range(0, 3), rvd, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
